grid_plotter: RTL

//   Sweeps the 28x28 one-bit drawing grid and writes it into the 160x120 vga_adapter framebuffer.

---
 rtl/grid_plotter_if.sv | 24 ++
 rtl/grid_plotter.sv | 115 +++++++++++
 2 files changed

// File: rtl/grid_plotter_if.sv
// grid_plotter_if: groups the sweep control, cell-memory read port and framebuffer write port of grid_plotter
interface grid_plotter_if;
    logic       start;
    logic [4:0] cursor_x;
    logic [4:0] cursor_y;
    logic [9:0] mem_addr;
    logic       mem_data;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    modport master (
        input  start, cursor_x, cursor_y, mem_data,
        output mem_addr, vga_x, vga_y, colour, plot, busy, done
    );

    modport slave (
        output start, cursor_x, cursor_y, mem_data,
        input  mem_addr, vga_x, vga_y, colour, plot, busy, done
    );
endinterface

// File: rtl/grid_plotter.sv
// grid_plotter: sweeps the one-bit cell grid into the VGA framebuffer, one CHUNK_SIZE block per cell.
// Define GRID_PLOTTER_CURSOR_EN to paint the cursor cell in CURSOR_COLOUR.
module grid_plotter #(
    parameter int         GRID_SIZE     = 28,
    parameter int         CHUNK_SIZE    = 4,
    parameter int         GRID_OFFSET_X = 24,
    parameter int         GRID_OFFSET_Y = 4,
    parameter logic [2:0] FG_COLOUR     = 3'b111,
    parameter logic [2:0] BG_COLOUR     = 3'b000,
    parameter logic [2:0] CURSOR_COLOUR = 3'b100
) (
    input logic            clock,
    input logic            reset,
    grid_plotter_if.master bus
);
    localparam int CW = $clog2(GRID_SIZE);
    localparam int SW = $clog2(CHUNK_SIZE);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, PAINT, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d, row_q, row_d;
    logic [SW-1:0] sub_x_q, sub_x_d, sub_y_q, sub_y_d;
    logic [2:0]    colour_q, colour_d;
    logic [7:0]    vga_x_q, vga_x_d;
    logic [6:0]    vga_y_q, vga_y_d;
    logic [9:0]    mem_addr_q, mem_addr_d;
    logic          cursor_hit, last_x, last_y, last_col, last_row;

`ifdef GRID_PLOTTER_CURSOR_EN
    // Cursor values past the grid edge can never equal a live col/row.
    assign cursor_hit = (32'(bus.cursor_x) == 32'(col_q)) && (32'(bus.cursor_y) == 32'(row_q));
`else
    logic unused_cursor;
    assign unused_cursor = ^{bus.cursor_x, bus.cursor_y};
    assign cursor_hit    = 1'b0;
`endif

    assign last_x   = sub_x_q == SW'(CHUNK_SIZE - 1);
    assign last_y   = sub_y_q == SW'(CHUNK_SIZE - 1);
    assign last_col = col_q == CW'(GRID_SIZE - 1);
    assign last_row = row_q == CW'(GRID_SIZE - 1);

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        sub_x_d  = sub_x_q;
        sub_y_d  = sub_y_q;
        colour_d = colour_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = FETCH;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                state_d  = PAINT;
                sub_x_d  = '0;
                sub_y_d  = '0;
                colour_d = cursor_hit ? CURSOR_COLOUR : (bus.mem_data ? FG_COLOUR : BG_COLOUR);
            end
            PAINT: begin
                sub_x_d = last_x ? '0 : sub_x_q + 1'b1;
                sub_y_d = last_x ? (last_y ? '0 : sub_y_q + 1'b1) : sub_y_q;
                if (last_x && last_y) begin
                    col_d   = last_col ? '0 : col_q + 1'b1;
                    row_d   = last_col ? row_q + 1'b1 : row_q;
                    state_d = (last_col && last_row) ? DONE : FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Pixel registers only move while painting, so they hold whenever plot is low.
        vga_x_d    = (state_d == PAINT) ? 8'(GRID_OFFSET_X + 32'(col_d) * CHUNK_SIZE + 32'(sub_x_d)) : vga_x_q;
        vga_y_d    = (state_d == PAINT) ? 7'(GRID_OFFSET_Y + 32'(row_d) * CHUNK_SIZE + 32'(sub_y_d)) : vga_y_q;
        mem_addr_d = (state_d == FETCH) ? 10'(32'(row_d) * GRID_SIZE + 32'(col_d)) : mem_addr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            sub_x_q    <= '0;
            sub_y_q    <= '0;
            colour_q   <= '0;
            vga_x_q    <= '0;
            vga_y_q    <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            sub_x_q    <= sub_x_d;
            sub_y_q    <= sub_y_d;
            colour_q   <= colour_d;
            vga_x_q    <= vga_x_d;
            vga_y_q    <= vga_y_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign bus.mem_addr = mem_addr_q;
    assign bus.vga_x    = vga_x_q;
    assign bus.vga_y    = vga_y_q;
    assign bus.colour   = colour_q;
    assign bus.plot     = state_q == PAINT;
    assign bus.busy     = state_q != IDLE;
    assign bus.done     = state_q == DONE;
endmodule
